// File: rtl/led_pattern_gen_if.sv
// ---------------------------------------------------------------------------
// led_pattern_gen_if
// Groups the control inputs and pattern outputs of led_pattern_gen.
//   en    : run enable. When low, the prescaler, pattern and direction freeze.
//   mode  : 00 bounce, 01 rotate-left, 10 rotate-right, 11 bar fill/drain
//   div   : step period minus one, in clock cycles
//   q     : registered LED pattern
//   step  : registered one-cycle pulse, high in the cycle q shows a new step
//   dir   : 1 = toward MSB / filling, 0 = toward LSB / draining
// The master modport drives the controls. The slave modport is the generator.
// ---------------------------------------------------------------------------
interface led_pattern_gen_if #(
    parameter int BITS  = 10,
    parameter int DIV_W = 24
);
    logic             en;
    logic [1:0]       mode;
    logic [DIV_W-1:0] div;
    logic [BITS-1:0]  q;
    logic             step;
    logic             dir;

    modport master (output en, mode, div, input q, step, dir);
    modport slave  (input en, mode, div, output q, step, dir);
endinterface

// File: rtl/led_pattern_gen.sv
// ---------------------------------------------------------------------------
// led_pattern_gen
// Prescaled LED pattern generator. It has four patterns: bounce, rotate-left,
// rotate-right and bar fill/drain.
// Ports:
//   clk : single clock. All state changes on the rising edge.
//   rst : asynchronous active-high reset
//   bus : led_pattern_gen_if.slave (en, mode, div in; q, step, dir out)
// Parameters:
//   BITS  : LED count (>= 2)
//   DIV_W : prescaler width
// ---------------------------------------------------------------------------
module led_pattern_gen #(
    parameter int BITS  = 10,
    parameter int DIV_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    led_pattern_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        MODE_BOUNCE = 2'b00,
        MODE_ROTL   = 2'b01,
        MODE_ROTR   = 2'b10,
        MODE_BAR    = 2'b11
    } mode_e;

    localparam logic [BITS-1:0]  ONE      = BITS'(1);
    localparam logic [BITS-1:0]  ALL_ONES = '1;
    localparam logic [DIV_W-1:0] CNT_ONE  = DIV_W'(1);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [BITS-1:0]  pattern_q, pattern_d;
    logic             dir_q, dir_d;
    logic             step_q, step_d;
    mode_e            mode_q, mode_d;

    logic             tick;
    logic             modeChange;

    assign tick       = bus.en & (cnt_q >= bus.div);
    assign modeChange = (bus.mode != mode_q);

    // State register. Reset leaves a single lit LED moving toward the MSB.
    // It also clears mode_q to bounce. Any other mode then reloads on the
    // first edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            pattern_q <= ONE;
            dir_q     <= 1'b1;
            step_q    <= 1'b0;
            mode_q    <= MODE_BOUNCE;
        end else begin
            cnt_q     <= cnt_d;
            pattern_q <= pattern_d;
            dir_q     <= dir_d;
            step_q    <= step_d;
            mode_q    <= mode_d;
        end
    end

    // Next-state logic. A mode change outranks everything, including a tick
    // in the same cycle. In that case the pattern restarts from bit 0 and no
    // step is reported. Otherwise the prescaler counts while enabled, and a
    // tick advances the pattern according to the registered mode.
    always_comb begin
        cnt_d     = cnt_q;
        pattern_d = pattern_q;
        dir_d     = dir_q;
        step_d    = 1'b0;
        mode_d    = mode_q;

        if (modeChange) begin
            pattern_d = ONE;
            dir_d     = 1'b1;
            cnt_d     = '0;
            mode_d    = mode_e'(bus.mode);
        end else if (tick) begin
            cnt_d  = '0;
            step_d = 1'b1;
            if ((mode_q != MODE_BAR) && (pattern_q == '0)) begin
                pattern_d = ONE;
                dir_d     = 1'b1;
            end else begin
                case (mode_q)
                    MODE_BOUNCE: begin
                        // Reverse on reaching a wall, stepping away in the same
                        // tick, so each end LED is shown for exactly one tick.
                        if (dir_q) begin
                            if (pattern_q[BITS-1]) begin
                                dir_d     = 1'b0;
                                pattern_d = pattern_q >> 1;
                            end else begin
                                pattern_d = pattern_q << 1;
                            end
                        end else begin
                            if (pattern_q[0]) begin
                                dir_d     = 1'b1;
                                pattern_d = pattern_q << 1;
                            end else begin
                                pattern_d = pattern_q >> 1;
                            end
                        end
                    end
                    MODE_ROTL: begin
                        pattern_d = {pattern_q[BITS-2:0], pattern_q[BITS-1]};
                        dir_d     = 1'b1;
                    end
                    MODE_ROTR: begin
                        pattern_d = {pattern_q[0], pattern_q[BITS-1:1]};
                        dir_d     = 1'b0;
                    end
                    MODE_BAR: begin
                        // Fill from bit 0 up, then drain by shifting zeros in.
                        if (dir_q) begin
                            if (pattern_q == ALL_ONES) begin
                                dir_d     = 1'b0;
                                pattern_d = pattern_q << 1;
                            end else begin
                                pattern_d = (pattern_q << 1) | ONE;
                            end
                        end else begin
                            if (pattern_q == '0) begin
                                dir_d     = 1'b1;
                                pattern_d = ONE;
                            end else begin
                                pattern_d = pattern_q << 1;
                            end
                        end
                    end
                    default: begin
                        pattern_d = ONE;
                        dir_d     = 1'b1;
                    end
                endcase
            end
        end else if (bus.en) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    assign bus.q    = pattern_q;
    assign bus.step = step_q;
    assign bus.dir  = dir_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_led_pattern_gen
// Directed bench for led_pattern_gen at BITS=4. Inputs change on the falling
// edge. Outputs are compared on the falling edge after each rising edge.
// ---------------------------------------------------------------------------
module tb_led_pattern_gen;

    localparam int BITS  = 4;
    localparam int DIV_W = 24;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    led_pattern_gen_if #(.BITS(BITS), .DIV_W(DIV_W)) ledIf ();

    led_pattern_gen #(.BITS(BITS), .DIV_W(DIV_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ledIf.slave)
    );

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the control inputs together.
    task automatic applyStimulus(input logic en, input logic [1:0] mode,
                                 input logic [DIV_W-1:0] div);
        ledIf.en   = en;
        ledIf.mode = mode;
        ledIf.div  = div;
    endtask

    // Compare the registered outputs against hand-computed values.
    task automatic checkOutput(input string tag, input logic [BITS-1:0] expQ,
                               input logic expDir, input logic expStep);
        vectors++;
        assert ({ledIf.q, ledIf.dir, ledIf.step} === {expQ, expDir, expStep})
        else begin
            miscompares++;
            $error("[TB] FAIL %s: got q=%b dir=%b step=%b, want q=%b dir=%b step=%b",
                   tag, ledIf.q, ledIf.dir, ledIf.step, expQ, expDir, expStep);
        end
    endtask

    // Advance one clock edge, then check.
    task automatic edgeCheck(input string tag, input logic [BITS-1:0] expQ,
                             input logic expDir, input logic expStep);
        @(negedge clk);
        checkOutput(tag, expQ, expDir, expStep);
    endtask

    // Directed sequence.
    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        applyStimulus(1'b0, 2'b00, '0);

        @(negedge clk);
        checkOutput("reset", 4'b0001, 1'b1, 1'b0);

        // Bounce with div=0: step every cycle, reversing at both walls.
        rst = 1'b0;
        applyStimulus(1'b1, 2'b00, 24'd0);
        edgeCheck("bounce0", 4'b0010, 1'b1, 1'b1);
        edgeCheck("bounce1", 4'b0100, 1'b1, 1'b1);
        edgeCheck("bounce2", 4'b1000, 1'b1, 1'b1);
        edgeCheck("bounce3", 4'b0100, 1'b0, 1'b1);
        edgeCheck("bounce4", 4'b0010, 1'b0, 1'b1);
        edgeCheck("bounce5", 4'b0001, 1'b0, 1'b1);
        edgeCheck("bounce6", 4'b0010, 1'b1, 1'b1);
        edgeCheck("bounce7", 4'b0100, 1'b1, 1'b1);

        // div=3: one step in four. Then a freeze with en=0.
        applyStimulus(1'b1, 2'b00, 24'd3);
        edgeCheck("div3_w0", 4'b0100, 1'b1, 1'b0);
        edgeCheck("div3_w1", 4'b0100, 1'b1, 1'b0);
        edgeCheck("div3_w2", 4'b0100, 1'b1, 1'b0);
        edgeCheck("div3_step", 4'b1000, 1'b1, 1'b1);
        edgeCheck("div3_after", 4'b1000, 1'b1, 1'b0);
        applyStimulus(1'b0, 2'b00, 24'd3);
        for (int i = 0; i < 10; i++) edgeCheck("freeze", 4'b1000, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'b00, 24'd3);
        edgeCheck("resume_w0", 4'b1000, 1'b1, 1'b0);
        edgeCheck("resume_w1", 4'b1000, 1'b1, 1'b0);
        edgeCheck("resume_step", 4'b0100, 1'b0, 1'b1);

        // Bar fill/drain with div=0. The mode change reloads first.
        applyStimulus(1'b1, 2'b11, 24'd0);
        edgeCheck("bar_reload", 4'b0001, 1'b1, 1'b0);
        edgeCheck("bar0", 4'b0011, 1'b1, 1'b1);
        edgeCheck("bar1", 4'b0111, 1'b1, 1'b1);
        edgeCheck("bar2", 4'b1111, 1'b1, 1'b1);
        edgeCheck("bar3", 4'b1110, 1'b0, 1'b1);
        edgeCheck("bar4", 4'b1100, 1'b0, 1'b1);
        edgeCheck("bar5", 4'b1000, 1'b0, 1'b1);
        edgeCheck("bar6", 4'b0000, 1'b0, 1'b1);
        edgeCheck("bar7", 4'b0001, 1'b1, 1'b1);

        // Rotate-left, then switch to rotate-right at q=0100. The reload wins
        // over the tick that would otherwise happen.
        applyStimulus(1'b1, 2'b01, 24'd0);
        edgeCheck("rotl_reload", 4'b0001, 1'b1, 1'b0);
        edgeCheck("rotl0", 4'b0010, 1'b1, 1'b1);
        edgeCheck("rotl1", 4'b0100, 1'b1, 1'b1);
        applyStimulus(1'b1, 2'b10, 24'd0);
        edgeCheck("rotr_reload", 4'b0001, 1'b1, 1'b0);
        edgeCheck("rotr0", 4'b1000, 1'b0, 1'b1);
        edgeCheck("rotr1", 4'b0100, 1'b0, 1'b1);
        edgeCheck("rotr2", 4'b0010, 1'b0, 1'b1);
        edgeCheck("rotr3", 4'b0001, 1'b0, 1'b1);
        edgeCheck("rotr4", 4'b1000, 1'b0, 1'b1);

        // Asynchronous reset pulse between edges while q=1000.
        applyStimulus(1'b1, 2'b10, 24'd2);
        #1 rst = 1'b1;
        #1 checkOutput("async_rst", 4'b0001, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'b00, 24'd2);
        #1 rst = 1'b0;
        edgeCheck("rel_w0", 4'b0001, 1'b1, 1'b0);
        edgeCheck("rel_w1", 4'b0001, 1'b1, 1'b0);
        edgeCheck("rel_step", 4'b0010, 1'b1, 1'b1);

        // Lower div from 100 to 2 while cnt is 50.
        applyStimulus(1'b1, 2'b00, 24'd100);
        for (int i = 0; i < 50; i++) @(negedge clk);
        checkOutput("div100_idle", 4'b0010, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'b00, 24'd2);
        edgeCheck("divdrop_step", 4'b0100, 1'b1, 1'b1);
        edgeCheck("divdrop_w0", 4'b0100, 1'b1, 1'b0);
        edgeCheck("divdrop_w1", 4'b0100, 1'b1, 1'b0);
        edgeCheck("divdrop_step2", 4'b1000, 1'b1, 1'b1);
        edgeCheck("divdrop_w2", 4'b1000, 1'b1, 1'b0);
        edgeCheck("divdrop_w3", 4'b1000, 1'b1, 1'b0);
        edgeCheck("divdrop_step3", 4'b0100, 1'b0, 1'b1);

        // Release reset with mode=01. The first edge reloads and q stays 1.
        rst = 1'b1;
        applyStimulus(1'b1, 2'b01, 24'd2);
        #2 rst = 1'b0;
        edgeCheck("rstmode_reload", 4'b0001, 1'b1, 1'b0);
        edgeCheck("rstmode_w0", 4'b0001, 1'b1, 1'b0);
        edgeCheck("rstmode_w1", 4'b0001, 1'b1, 1'b0);
        edgeCheck("rstmode_step", 4'b0010, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 SHALL have parameter BITS, default 10, LED count; legal range BITS >= 2.
REQ-002 SHALL have parameter DIV_W, default 24, prescaler width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port en  input  1  run enable; 0 freezes prescaler, q, dir.
REQ-006 SHALL have port mode  input  2  pattern: 00 bounce, 01 rotate-left, 10 rotate-right, 11 bar fill/drain.
REQ-007 SHALL have port div  input  DIV_W  step period minus one, in clk cycles.
REQ-008 SHALL have port q  output  BITS  LED pattern, registered.
REQ-009 SHALL have port step  output  1  one-cycle pulse, registered, high in the cycle q takes a new step value.
REQ-010 SHALL have port dir  output  1  current direction/phase: 1 = toward MSB / filling, 0 = toward LSB / draining.

Function
REQ-011 SHALL hold an internal counter cnt[DIV_W-1:0]; tick = en & (cnt >= div).
REQ-012 With en=1, cnt SHALL increment each cycle and clear to 0 on tick; with en=0, cnt SHALL hold.
REQ-013 A tick SHALL update q and dir on that edge and assert step for exactly that following cycle; step SHALL be 0 otherwise.
REQ-014 div=0 SHALL produce a tick every enabled cycle; lowering div below cnt mid-count SHALL tick on the next enabled cycle (>= compare).
REQ-015 SHALL register mode into mode_q; when mode != mode_q, the next edge SHALL load q=1 (bit 0 only), dir=1, cnt=0, step=0, mode_q=mode, regardless of en or tick.
REQ-016 Bounce (00): dir=1 -> if q[BITS-1] then dir<=0, q<=q>>1 else q<=q<<1; dir=0 -> if q[0] then dir<=1, q<=q<<1 else q<=q>>1.
REQ-017 Bounce period SHALL be 2*(BITS-1) ticks; an end LED SHALL be shown for exactly one tick (no repeat at the walls).
REQ-018 Rotate-left (01): q <= {q[BITS-2:0], q[BITS-1]}; dir held at 1.
REQ-019 Rotate-right (10): q <= {q[0], q[BITS-1:1]}; dir held at 0 from the first tick.
REQ-020 Bar (11), dir=1: if q all ones then dir<=0, q<=q<<1 else q<=(q<<1)|1.
REQ-021 Bar (11), dir=0: if q==0 then dir<=1, q<=1 else q<=q<<1.
REQ-022 In modes 00/01/10, a tick with q==0 SHALL load q=1, dir=1 (self-recovery).
REQ-023 Mode change and tick in the same cycle: the mode-change reload (REQ-015) SHALL take priority and no step SHALL be issued.
REQ-024 All outputs SHALL be glitch-free register outputs; no combinational path from inputs to q, step, or dir.

Reset
REQ-025 rst=1 SHALL asynchronously force q=1, dir=1, step=0, cnt=0, mode_q=mode-independent 00.
REQ-026 The first edge after rst deassertion with mode != 00 SHALL perform the REQ-015 reload; q stays 1.
REQ-027 rst asserted mid-step or mid-count SHALL abort immediately; no step pulse SHALL follow release until a full div+1 enabled cycles elapse.

Verification
REQ-028 BITS=4, mode=00, div=0, en=1 after reset -> q sequence 0001,0010,0100,1000,0100,0010,0001,0010; dir toggles at 1000 and 0001; step high every cycle.
REQ-029 BITS=4, mode=00, div=3 -> step high one cycle in four; q constant between steps; en=0 for 10 cycles -> q, dir, cnt frozen, no step.
REQ-030 BITS=4, mode=11, div=0 -> q 0001,0011,0111,1111,1110,1100,1000,0000,0001; dir falls at 1111->1110 and rises at 0000->0001.
REQ-031 BITS=4, mode=01 running at q=0100, mode switched to 10 -> next edge q=0001, dir=1, step=0; the following ticks give 1000,0100,0010 with dir=0.
REQ-032 rst pulsed asynchronously between clock edges while q=1000 -> q=0001, step=0 immediately; with div=2, the first step comes on the 3rd enabled edge after release.
REQ-033 div reduced from 100 to 2 while cnt=50 -> tick on the next enabled edge, then every 3 cycles.
